// File: rtl/dsi_packet_assembler.sv
// DSI packet assembler: turns a header request plus an optional payload stream
// into the byte sequence DI, WC0, WC1, ECC [, payload, CRC0, CRC1] for one lane.
module dsi_packet_assembler (
    input  logic        clk_base,
    input  logic        reset_n,
    input  logic        pkt_valid,
    output logic        pkt_ready,
    input  logic        pkt_long,
    input  logic [7:0]  pkt_di,
    input  logic [15:0] pkt_wc,
    input  logic        pkt_hs,
    input  logic        pld_valid,
    input  logic [7:0]  pld_data,
    output logic        pld_ready,
    output logic        data_write,
    output logic [7:0]  data_input,
    output logic        data_type,
    output logic        end_of_frame,
    output logic        dummy_frame,
    input  logic        lane_data_ready,
    output logic        busy,
    output logic        underrun
);

    typedef enum logic [2:0] {IDLE, HDR, PLD, CRC0, CRC1} state_t;

    // Parity masks over {WC[15:8], WC[7:0], DI}, entry gi produces ECC bit gi
    localparam logic [5:0][23:0] ECC_MASK = {
        24'hEFFC00, 24'hDF03F0, 24'hB8E38E, 24'h749A6D, 24'hF2555B, 24'hF12CB7
    };

    state_t      state_reg, state_next;
    logic [7:0]  di_reg;
    logic [15:0] wc_reg;
    logic        long_reg;
    logic        hs_reg;
    logic [1:0]  hdr_idx_reg;
    logic [15:0] pld_cnt_reg;
    logic [15:0] crc_reg;
    logic        underrun_reg;
    logic [7:0]  hold_byte_reg;
    logic        hold_type_reg;
    logic        hold_eof_reg;

    logic [23:0] hdr_word;
    logic [5:0]  ecc;
    logic        byte_avail;
    logic [7:0]  cur_byte;
    logic        cur_eof;
    logic        pkt_accept;

    assign hdr_word = {wc_reg, di_reg};

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_ecc
            assign ecc[gi] = ^(hdr_word & ECC_MASK[gi]);
        end
    endgenerate

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ b[i]) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

    // State register
    always_ff @(posedge clk_base or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (pkt_valid) state_next = HDR;
            HDR: begin
                if (data_write && hdr_idx_reg == 2'd3) begin
                    if (!long_reg)          state_next = IDLE;
                    else if (wc_reg == '0)  state_next = CRC0;
                    else                    state_next = PLD;
                end
            end
            PLD:  if (data_write && pld_cnt_reg == 16'd1) state_next = CRC0;
            CRC0: if (data_write) state_next = CRC1;
            CRC1: if (data_write) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        byte_avail = 1'b0;
        cur_byte   = 8'h00;
        cur_eof    = 1'b0;
        pld_ready  = 1'b0;
        case (state_reg)
            HDR: begin
                byte_avail = 1'b1;
                case (hdr_idx_reg)
                    2'd0: cur_byte = di_reg;
                    2'd1: cur_byte = wc_reg[7:0];
                    2'd2: cur_byte = wc_reg[15:8];
                    default: begin
                        cur_byte = {2'b00, ecc};
                        cur_eof  = !long_reg;
                    end
                endcase
            end
            PLD: begin
                byte_avail = pld_valid;
                cur_byte   = pld_data;
                pld_ready  = lane_data_ready;
            end
            CRC0: begin
                byte_avail = 1'b1;
                cur_byte   = crc_reg[7:0];
            end
            CRC1: begin
                byte_avail = 1'b1;
                cur_byte   = crc_reg[15:8];
                cur_eof    = 1'b1;
            end
            default: ;
        endcase
    end

    assign pkt_ready    = (state_reg == IDLE);
    assign busy         = (state_reg != IDLE);
    assign pkt_accept   = pkt_valid && pkt_ready;
    assign data_write   = byte_avail && lane_data_ready;
    // Between strobes the lane sees the last written byte, not a moving payload input
    assign data_input   = data_write ? cur_byte : hold_byte_reg;
    assign data_type    = data_write ? hs_reg   : hold_type_reg;
    assign end_of_frame = data_write ? cur_eof  : hold_eof_reg;
    assign dummy_frame  = 1'b0;
    assign underrun     = underrun_reg;

    // Datapath: latched header, counters, CRC and sticky flag
    always_ff @(posedge clk_base or negedge reset_n) begin
        if (!reset_n) begin
            di_reg        <= '0;
            wc_reg        <= '0;
            long_reg      <= 1'b0;
            hs_reg        <= 1'b0;
            hdr_idx_reg   <= '0;
            pld_cnt_reg   <= '0;
            crc_reg       <= 16'hFFFF;
            underrun_reg  <= 1'b0;
            hold_byte_reg <= '0;
            hold_type_reg <= 1'b0;
            hold_eof_reg  <= 1'b0;
        end else begin
            if (pkt_accept) begin
                di_reg      <= pkt_di;
                wc_reg      <= pkt_wc;
                long_reg    <= pkt_long;
                hs_reg      <= pkt_hs;
                hdr_idx_reg <= '0;
                crc_reg     <= 16'hFFFF;
            end
            if (state_reg == HDR && data_write) begin
                hdr_idx_reg <= hdr_idx_reg + 2'd1;
                if (hdr_idx_reg == 2'd3) pld_cnt_reg <= wc_reg;
            end
            if (state_reg == PLD && data_write) begin
                pld_cnt_reg <= pld_cnt_reg - 16'd1;
                crc_reg     <= crc16_byte(crc_reg, pld_data);
            end
            if (state_reg == PLD && lane_data_ready && !pld_valid && hs_reg) begin
                underrun_reg <= 1'b1;
            end
            if (data_write) begin
                hold_byte_reg <= cur_byte;
                hold_type_reg <= hs_reg;
                hold_eof_reg  <= cur_eof;
            end
        end
    end

endmodule

// File: tb/tb_dsi_packet_assembler.sv
// Scoreboard bench for dsi_packet_assembler: the driver queues expected lane bytes,
// a negedge monitor pops and compares them on every data_write.
module tb_dsi_packet_assembler;

    logic        clk_base = 1'b0;
    logic        reset_n  = 1'b0;
    logic        pkt_valid = 1'b0;
    logic        pkt_ready;
    logic        pkt_long = 1'b0;
    logic [7:0]  pkt_di = '0;
    logic [15:0] pkt_wc = '0;
    logic        pkt_hs = 1'b0;
    logic        pld_valid = 1'b0;
    logic [7:0]  pld_data = '0;
    logic        pld_ready;
    logic        data_write;
    logic [7:0]  data_input;
    logic        data_type;
    logic        end_of_frame;
    logic        dummy_frame;
    logic        lane_data_ready = 1'b1;
    logic        busy;
    logic        underrun;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int first_wr = -1;
    int last_wr = -1;
    bit toggle_mode = 1'b0;
    bit pld_ready_seen = 1'b0;
    logic [9:0] exp_q[$];
    logic [7:0] payload [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    dsi_packet_assembler dut (
        .clk_base(clk_base), .reset_n(reset_n),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_long(pkt_long),
        .pkt_di(pkt_di), .pkt_wc(pkt_wc), .pkt_hs(pkt_hs),
        .pld_valid(pld_valid), .pld_data(pld_data), .pld_ready(pld_ready),
        .data_write(data_write), .data_input(data_input), .data_type(data_type),
        .end_of_frame(end_of_frame), .dummy_frame(dummy_frame),
        .lane_data_ready(lane_data_ready), .busy(busy), .underrun(underrun)
    );

    initial forever #5 clk_base = ~clk_base;
    initial forever begin
        @(posedge clk_base);
        cyc++;
    end

    initial forever begin
        @(posedge clk_base);
        #1;
        lane_data_ready = toggle_mode ? ~lane_data_ready : 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every lane write must match the head of the scoreboard queue
    initial forever begin
        logic [9:0] e;
        @(negedge clk_base);
        if (pld_ready) pld_ready_seen = 1'b1;
        if (data_write) begin
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            check("write_while_lane_ready", {31'd0, lane_data_ready}, 32'd1);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got %02h expected no write", data_input);
            end else begin
                e = exp_q.pop_front();
                check("lane_byte{type,eof,data}", {22'd0, data_type, end_of_frame, data_input}, {22'd0, e});
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_pkt_ready",    {31'd0, pkt_ready},    32'd1);
        check("rst_data_write",   {31'd0, data_write},   32'd0);
        check("rst_pld_ready",    {31'd0, pld_ready},    32'd0);
        check("rst_data_input",   {24'd0, data_input},   32'd0);
        check("rst_data_type",    {31'd0, data_type},    32'd0);
        check("rst_end_of_frame", {31'd0, end_of_frame}, 32'd0);
        check("rst_busy",         {31'd0, busy},         32'd0);
        check("rst_underrun",     {31'd0, underrun},     32'd0);
        check("rst_dummy_frame",  {31'd0, dummy_frame},  32'd0);
    endtask

    task automatic send_pkt(input bit lng, input logic [7:0] di, input logic [15:0] wc,
                            input bit hs, input logic [7:0] exp_ecc, input logic [15:0] exp_crc,
                            input int gap_at, input int abort_after);
        bit ok;
        exp_q.push_back({hs, 1'b0, di});
        exp_q.push_back({hs, 1'b0, wc[7:0]});
        exp_q.push_back({hs, 1'b0, wc[15:8]});
        exp_q.push_back({hs, !lng, exp_ecc});
        if (lng) begin
            for (int k = 0; k < int'(wc); k++) exp_q.push_back({hs, 1'b0, payload[k]});
            exp_q.push_back({hs, 1'b0, exp_crc[7:0]});
            exp_q.push_back({hs, 1'b1, exp_crc[15:8]});
        end
        @(posedge clk_base);
        #1;
        pkt_valid = 1'b1; pkt_long = lng; pkt_di = di; pkt_wc = wc; pkt_hs = hs;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk_base);
            if (pkt_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("header_accept_timeout", 32'd0, 32'd1);
        @(posedge clk_base);
        #1;
        pkt_valid = 1'b0;
        if (lng) begin
            for (int k = 0; k < int'(wc); k++) begin
                if (k == gap_at) begin
                    pld_valid = 1'b0;
                    repeat (2) @(posedge clk_base);
                    #1;
                end
                pld_valid = 1'b1;
                pld_data  = payload[k];
                ok = 1'b0;
                for (int t = 0; t < 100; t++) begin
                    @(negedge clk_base);
                    if (pld_ready) begin ok = 1'b1; break; end
                end
                if (!ok) check("payload_accept_timeout", 32'd0, 32'd1);
                @(posedge clk_base);
                #1;
                if (k + 1 == abort_after) begin
                    reset_n = 1'b0;
                    pld_valid = 1'b0;
                    exp_q.delete();
                    @(negedge clk_base);
                    check_reset_outputs();
                    @(posedge clk_base);
                    #1;
                    reset_n = 1'b1;
                    repeat (4) @(posedge clk_base);
                    #1;
                    check("abort_no_resume_busy", {31'd0, busy}, 32'd0);
                    return;
                end
            end
            pld_valid = 1'b0;
        end
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk_base);
            if (exp_q.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) check("packet_drain_timeout", exp_q.size(), 32'd0);
        @(posedge clk_base);
        #1;
        check("idle_busy_after_pkt", {31'd0, busy}, 32'd0);
        check("idle_pkt_ready_after_pkt", {31'd0, pkt_ready}, 32'd1);
    endtask

    initial begin
        #2;
        @(negedge clk_base);
        check_reset_outputs();
        @(posedge clk_base);
        #1;
        reset_n = 1'b1;

        // Short packet: 05 11 00 36 back to back
        first_wr = -1;
        send_pkt(1'b0, 8'h05, 16'h0011, 1'b0, 8'h36, 16'h0000, -1, -1);
        check("short_consecutive_span", last_wr - first_wr, 32'd3);

        // Long packet "123456789": CRC 0x6F91
        send_pkt(1'b1, 8'h39, 16'd9, 1'b0, 8'h30, 16'h6F91, -1, -1);

        // Zero-length long packet
        pld_ready_seen = 1'b0;
        send_pkt(1'b1, 8'h39, 16'd0, 1'b0, 8'h0F, 16'hFFFF, -1, -1);
        check("wc0_pld_ready_never", {31'd0, pld_ready_seen}, 32'd0);

        // Lane ready toggling every cycle
        toggle_mode = 1'b1;
        send_pkt(1'b1, 8'h39, 16'd9, 1'b1, 8'h30, 16'h6F91, -1, -1);
        toggle_mode = 1'b0;
        check("toggle_no_underrun", {31'd0, underrun}, 32'd0);

        // Payload gap with hs=1 sets sticky underrun
        send_pkt(1'b1, 8'h39, 16'd9, 1'b1, 8'h30, 16'h6F91, 4, -1);
        check("underrun_set", {31'd0, underrun}, 32'd1);
        repeat (3) @(posedge clk_base);
        #1;
        check("underrun_sticky", {31'd0, underrun}, 32'd1);

        // Reset after the 3rd payload byte, then a clean packet
        send_pkt(1'b1, 8'h39, 16'd9, 1'b0, 8'h30, 16'h6F91, -1, 3);
        send_pkt(1'b1, 8'h39, 16'd9, 1'b0, 8'h30, 16'h6F91, -1, -1);
        check("post_reset_underrun", {31'd0, underrun}, 32'd0);

        repeat (3) @(posedge clk_base);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/dsi_packet_assembler.md
DSI_PACKET_ASSEMBLER -- requirements
Module: dsi_packet_assembler

Interface
REQ-001 SHALL have parameter: none; all timing is fixed by the handshake rules below.
REQ-002 SHALL have port: clk_base  in  1  logic clock, shared with the downstream lane.
REQ-003 SHALL have port: reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: pkt_valid  in  1  packet header request.
REQ-005 SHALL have port: pkt_ready  out  1  header accepted when pkt_valid && pkt_ready.
REQ-006 SHALL have port: pkt_long  in  1  1 = long packet (header, payload, CRC); 0 = short packet (header only).
REQ-007 SHALL have port: pkt_di  in  8  Data Identifier byte (VC[7:6], DT[5:0]).
REQ-008 SHALL have port: pkt_wc  in  16  word count for long packets; {data1, data0} for short packets.
REQ-009 SHALL have port: pkt_hs  in  1  value driven on data_type for the whole packet.
REQ-010 SHALL have port: pld_valid  in  1  payload byte available.
REQ-011 SHALL have port: pld_data  in  8  payload byte.
REQ-012 SHALL have port: pld_ready  out  1  payload byte consumed when pld_valid && pld_ready.
REQ-013 SHALL have port: data_write  out  1  byte strobe to the lane.
REQ-014 SHALL have port: data_input  out  8  byte to the lane.
REQ-015 SHALL have port: data_type  out  1  to the lane.
REQ-016 SHALL have port: end_of_frame  out  1  last byte of the packet.
REQ-017 SHALL have port: dummy_frame  out  1  tied 0.
REQ-018 SHALL have port: lane_data_ready  in  1  lane can accept a byte this cycle.
REQ-019 SHALL have port: busy  out  1  high in every state except IDLE.
REQ-020 SHALL have port: underrun  out  1  sticky flag, cleared only by reset.

Function
REQ-021 SHALL implement FSM states IDLE, HDR, PLD, CRC0, CRC1.
REQ-022 SHALL drive pkt_ready = (state == IDLE).
REQ-023 SHALL, on header acceptance, latch DI, WC, long and hs, then enter HDR with byte index 0.
REQ-024 SHALL emit header bytes in order: DI, WC[7:0], WC[15:8], ECC.
REQ-025 SHALL emit exactly one byte per cycle in which data_write is high.
REQ-026 SHALL drive data_write = byte_available && lane_data_ready, and never drive it high while lane_data_ready is low.
REQ-027 SHALL have ECC = 6-bit Hamming code per MIPI DSI over {WC[15:8], WC[7:0], DI} with ECC[7:6] = 0, computed combinationally from the latched fields.
REQ-028 SHALL, for a short packet, return to IDLE after the ECC byte is written, with end_of_frame high on that byte.
REQ-029 SHALL, for a long packet with WC > 0, go from HDR to PLD after the ECC byte, with a 16-bit payload down-counter loaded with WC.
REQ-030 SHALL, in PLD, drive pld_ready = lane_data_ready, forward pld_data, and drive data_write = pld_valid && lane_data_ready.
REQ-031 SHALL decrement the payload counter per byte written and go to CRC0 when it reaches 0.
REQ-032 SHALL go directly from HDR to CRC0 when WC = 0.
REQ-033 SHALL compute CRC-16 (poly x^16+x^12+x^5+1, reflected 0x8408, init 0xFFFF, LSB first, no final XOR) over payload bytes only.
REQ-034 SHALL re-initialise the CRC to 0xFFFF on header acceptance.
REQ-035 SHALL send CRC[7:0] in CRC0 and CRC[15:8] in CRC1, with end_of_frame high on CRC1, then return to IDLE.
REQ-036 SHALL set underrun when state == PLD && lane_data_ready && !pld_valid && pkt_hs; the FSM stalls without emitting a byte.
REQ-037 SHALL drive pld_ready low outside PLD.
REQ-038 SHALL hold data_input, data_type and end_of_frame stable while data_write is low.
REQ-039 SHALL accept a new header in the cycle after the last byte (one IDLE cycle minimum between packets).

Reset
REQ-040 SHALL, while reset_n is low, force: state IDLE, pkt_ready 1, data_write 0, pld_ready 0, data_input 0x00, data_type 0, end_of_frame 0, busy 0, underrun 0, CRC 0xFFFF, counters 0.
REQ-041 SHALL, on reset asserted mid-packet, abort the packet immediately; no partial packet resumes after release.

Verification
REQ-042 SHALL pass: short packet DI=0x05, WC=0x0011, lane_data_ready always 1 -> bytes 05 11 00 36 in 4 consecutive cycles, end_of_frame only on 0x36.
REQ-043 SHALL pass: long packet DI=0x39, WC=9, payload ASCII "123456789" -> 4 header bytes, 9 payload bytes, then 91 6F; end_of_frame on 0x6F; total 15 writes.
REQ-044 SHALL pass: long packet WC=0 -> header, then FF FF; pld_ready never high.
REQ-045 SHALL pass: lane_data_ready toggling 1/0 each cycle during a long packet -> data_write never high while ready is low; byte sequence identical to the REQ-043 case.
REQ-046 SHALL pass: pld_valid dropped for 2 cycles mid-payload with pkt_hs=1 -> underrun=1 and stays 1; payload order intact.
REQ-047 SHALL pass: reset_n pulsed low after the 3rd payload byte -> all outputs at REQ-040 values; next packet starts cleanly with CRC init 0xFFFF.
